// File: rtl/mul_share_arb_pkg.sv
// Shared types for the multiplier-sharing arbiter: op flags, requester ids
// and the in-flight tag carried through the tag FIFO.
package mul_share_arb_pkg;

  // Bit positions of the flag nibble {signed, mul64, hi, short}.
  localparam int MUL_FLAG_SIGNED = 3;
  localparam int MUL_FLAG_MUL64  = 2;
  localparam int MUL_FLAG_HI     = 1;
  localparam int MUL_FLAG_SHORT  = 0;

  typedef struct packed {
    logic is_signed;
    logic mul64;
    logic hi;
    logic is_short;
  } mul_flags_t;

  // REQ_EX is the integer EX pipe, REQ_AUX the address-gen / CSR helper.
  typedef enum logic {
    REQ_EX  = 1'b0,
    REQ_AUX = 1'b1
  } req_id_t;

  typedef struct packed {
    req_id_t id;
    logic    killed;
  } tag_entry_t;

endpackage

// File: rtl/mul_tag_fifo.sv
// In-order tag FIFO recording the owner of every op in flight in the
// multiplier, with a broadcast kill that marks all of one owner's tags.
module mul_tag_fifo
  import mul_share_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         push,
  input  req_id_t                      push_id,
  input  logic                         pop,
  input  logic [1:0]                   kill,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output tag_entry_t                   head
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  tag_entry_t       entries [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign do_push = push && (count != FULL);
  assign do_pop  = pop && (count != '0);
  assign head    = entries[rd_ptr];

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: tag storage is not reset; count gates every read of head, and a
  // push always rewrites both fields, so stale or killed-while-empty slots
  // are harmless.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (kill[entries[i].id]) entries[i].killed <= 1'b1;
    end
    if (do_push) entries[wr_ptr] <= '{id: push_id, killed: 1'b0};
  end

endmodule

// File: rtl/mul_share_arb.sv
// Round-robin arbiter sharing one iterative multiplier between the EX pipe
// (req0) and the auxiliary unit (req1); results are routed back by tag.
module mul_share_arb
  import mul_share_arb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic         clk,
  input  logic         rstn,

  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_opa,
  input  logic [W-1:0] req0_opb,
  input  logic [3:0]   req0_flags,
  input  logic         kill0,

  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_opa,
  input  logic [W-1:0] req1_opb,
  input  logic [3:0]   req1_flags,
  input  logic         kill1,

  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [W-1:0] rsp_res,

  output logic         m_valid,
  input  logic         m_allowin,
  output logic [W-1:0] m_opa,
  output logic [W-1:0] m_opb,
  output logic [3:0]   m_flags,

  input  logic         m_res_valid,
  output logic         m_res_ready,
  input  logic [W-1:0] m_res,

  output logic         busy
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [CNT_W-1:0] count;
  tag_entry_t       head;
  req_id_t          rr_last;
  req_id_t          push_id;
  mul_flags_t       sel_flags;
  logic             can_issue;
  logic             act0;
  logic             act1;
  logic             grant0;
  logic             grant1;
  logic             has_head;
  logic             pop;

  // A slot freed by this cycle's pop is not reusable until the next cycle.
  assign can_issue = rstn && m_allowin && (count < FULL);

  // A killed requester neither wins a grant nor blocks the other one.
  assign act0 = req0_valid && !kill0;
  assign act1 = req1_valid && !kill1;

  assign req0_ready = can_issue && !kill0 && (!act1 || rr_last != REQ_EX);
  assign req1_ready = can_issue && !kill1 && (!act0 || rr_last != REQ_AUX);

  assign grant0  = req0_valid && req0_ready;
  assign grant1  = req1_valid && req1_ready;
  assign m_valid = grant0 || grant1;

  // NOTE: every signal driven here gets a default first, so no latch forms.
  always_comb begin
    push_id   = REQ_EX;
    m_opa     = req0_opa;
    m_opb     = req0_opb;
    sel_flags = mul_flags_t'(req0_flags);
    if (grant1) begin
      push_id   = REQ_AUX;
      m_opa     = req1_opa;
      m_opb     = req1_opb;
      sel_flags = mul_flags_t'(req1_flags);
    end
  end

  assign m_flags = sel_flags;

  assign has_head   = (count != '0);
  assign busy       = has_head;
  assign rsp_res    = m_res;
  assign rsp0_valid = rstn && m_res_valid && has_head && !head.killed && (head.id == REQ_EX);
  assign rsp1_valid = rstn && m_res_valid && has_head && !head.killed && (head.id == REQ_AUX);

  // Killed tags and orphan results are drained unconditionally.
  always_comb begin
    m_res_ready = 1'b0;
    if (rstn) begin
      if (!has_head || head.killed) m_res_ready = 1'b1;
      else if (head.id == REQ_AUX)  m_res_ready = rsp1_ready;
      else                          m_res_ready = rsp0_ready;
    end
  end

  assign pop = m_res_valid && m_res_ready && has_head;

  always_ff @(posedge clk) begin
    if (!rstn)        rr_last <= REQ_AUX;
    else if (m_valid) rr_last <= push_id;
  end

  mul_tag_fifo #(
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push    (m_valid),
    .push_id (push_id),
    .pop     (pop),
    .kill    ({kill1, kill0}),
    .count   (count),
    .head    (head)
  );

  // A result with nothing in flight means the multiplier broke ordering.
  no_orphan_result: assert property (@(posedge clk) disable iff (!rstn)
    !(m_res_valid && !has_head));

endmodule

// File: tb/tb_mul_share_arb.sv
// Self-checking bench: the bench plays the multiplier, a scoreboard of tags
// predicts grants, routing and kills, and directed scenarios add spot checks.
module tb_mul_share_arb;
  import mul_share_arb_pkg::*;

  localparam int DEPTH = 2;
  localparam int W     = 64;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_opa = '0, req0_opb = '0, req1_opa = '0, req1_opb = '0;
  logic [3:0]   req0_flags = '0, req1_flags = '0;
  logic         kill0 = 1'b0, kill1 = 1'b0;
  logic         rsp0_valid, rsp1_valid;
  logic         rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [W-1:0] rsp_res;
  logic         m_valid;
  logic         m_allowin = 1'b1;
  logic [W-1:0] m_opa, m_opb;
  logic [3:0]   m_flags;
  logic         m_res_valid = 1'b0;
  logic         m_res_ready;
  logic [W-1:0] m_res = '0;
  logic         busy;

  mul_share_arb #(.DEPTH(DEPTH), .W(W)) dut (
    .clk(clk), .rstn(rstn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opa(req0_opa),
    .req0_opb(req0_opb), .req0_flags(req0_flags), .kill0(kill0),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opa(req1_opa),
    .req1_opb(req1_opb), .req1_flags(req1_flags), .kill1(kill1),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp_res(rsp_res),
    .m_valid(m_valid), .m_allowin(m_allowin), .m_opa(m_opa), .m_opb(m_opb),
    .m_flags(m_flags), .m_res_valid(m_res_valid), .m_res_ready(m_res_ready),
    .m_res(m_res), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard of in-flight ops (mirrors what the DUT should hold) and the
  // bench's own multiplier pipeline returning results in issue order.
  typedef struct { req_id_t id; logic killed; logic [W-1:0] res; } sb_t;
  typedef struct { logic [W-1:0] res; int due; } mq_t;
  sb_t     sb[$];
  mq_t     mq[$];
  int      grants[$];
  int      cyc = 0;
  int      mul_lat = 2;
  bit      mres_taken = 1'b0;
  req_id_t rr_m = REQ_AUX;
  int      n_rsp0 = 0;
  int      n_rsp1 = 0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (mres_taken) begin
      mres_taken = 1'b0;
      if (mq.size() != 0) mq.delete(0);
    end
    if (mq.size() != 0 && mq[0].due <= cyc) begin
      m_res_valid = 1'b1;
      m_res       = mq[0].res;
    end else begin
      m_res_valid = 1'b0;
      m_res       = '0;
    end
  end

  // Sampled mid-cycle: the values seen here are what the next edge commits.
  task automatic monitor_step();
    sb_t          h;
    int           n;
    logic         e0, e1, emrr, a0, a1, can, eg0, eg1;
    req_id_t      gid;
    logic [W-1:0] opa, opb, prod;
    logic [3:0]   fl;
    int           due;
    if (!rstn) begin
      check("rst_outs", W'({req0_ready, req1_ready, rsp0_valid, rsp1_valid, m_valid, m_res_ready}), '0);
      sb.delete();
      mq.delete();
      mres_taken = 1'b0;
      rr_m = REQ_AUX;
      return;
    end
    n = sb.size();
    check("busy", W'(busy), W'(n != 0));
    e0 = 1'b0; e1 = 1'b0; emrr = 1'b1;
    h = '{id: REQ_EX, killed: 1'b0, res: '0};
    if (n != 0) begin
      h = sb[0];
      if (!h.killed) begin
        emrr = (h.id == REQ_AUX) ? rsp1_ready : rsp0_ready;
        e0 = m_res_valid && (h.id == REQ_EX);
        e1 = m_res_valid && (h.id == REQ_AUX);
      end
    end
    check("rsp_valid", W'({rsp1_valid, rsp0_valid}), W'({e1, e0}));
    check("m_res_ready", W'(m_res_ready), W'(emrr));
    if (e0 || e1) check("rsp_res", rsp_res, h.res);
    if (rsp0_valid && rsp0_ready) n_rsp0++;
    if (rsp1_valid && rsp1_ready) n_rsp1++;
    if (m_res_valid && m_res_ready && n != 0) begin
      sb.delete(0);
      mres_taken = 1'b1;
    end
    for (int i = 0; i < sb.size(); i++) begin
      if ((kill0 && sb[i].id == REQ_EX) || (kill1 && sb[i].id == REQ_AUX)) sb[i].killed = 1'b1;
    end
    a0  = req0_valid && !kill0;
    a1  = req1_valid && !kill1;
    can = m_allowin && (n < DEPTH);
    eg0 = can && a0 && (!a1 || rr_m != REQ_EX);
    eg1 = can && a1 && (!a0 || rr_m != REQ_AUX);
    check("grant", W'({req1_valid && req1_ready, req0_valid && req0_ready}), W'({eg1, eg0}));
    check("m_valid", W'(m_valid), W'(eg0 || eg1));
    if (eg0 || eg1) begin
      gid = eg1 ? REQ_AUX : REQ_EX;
      opa = eg1 ? req1_opa : req0_opa;
      opb = eg1 ? req1_opb : req0_opb;
      fl  = eg1 ? req1_flags : req0_flags;
      check("m_opa", m_opa, opa);
      check("m_opb", m_opb, opb);
      check("m_flags", W'(m_flags), W'(fl));
      prod = opa * opb;
      due  = cyc + mul_lat;
      if (mq.size() != 0 && mq[mq.size()-1].due > due) due = mq[mq.size()-1].due;
      sb.push_back('{id: gid, killed: 1'b0, res: prod});
      mq.push_back('{res: prod, due: due});
      rr_m = gid;
      grants.push_back(int'(gid));
    end
  endtask

  always @(negedge clk) monitor_step();

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [3:0] f, input string tag);
    int k = 0;
    if (r == 0) begin req0_valid = 1'b1; req0_opa = a; req0_opb = b; req0_flags = f; end
    else        begin req1_valid = 1'b1; req1_opa = a; req1_opb = b; req1_flags = f; end
    #1;
    while (!((r == 0) ? req0_ready : req1_ready) && k < 50) begin tick(); k++; end
    check({tag, "_granted"}, W'(k < 50), W'(1));
    tick();
    if (r == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
  endtask

  task automatic wait_res(input string tag);
    int k = 0;
    while (!m_res_valid && k < 50) begin tick(); k++; end
    check({tag, "_res_seen"}, W'(k < 50), W'(1));
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while ((busy || mq.size() != 0) && k < 200) begin tick(); k++; end
    check({tag, "_drained"}, W'(k < 200), W'(1));
  endtask

  initial begin
    int r0, r1, base;
    logic [3:0] f;
    #(2_000_000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r0, r1, base, k;
    logic [3:0] f;
    tick(3);
    rstn = 1'b1;
    check("post_rst_busy", W'(busy), W'(0));

    // Single req0 op: 3*5 returns two cycles after issue.
    mul_lat = 2;
    r0 = n_rsp0; r1 = n_rsp1;
    send(0, 64'd3, 64'd5, 4'b0000, "t1");
    check("t1_not_yet", W'(m_res_valid), W'(0));
    tick();
    check("t1_rsp0_v", W'(rsp0_valid), W'(1));
    check("t1_res", rsp_res, 64'd15);
    check("t1_rsp1_v", W'(rsp1_valid), W'(0));
    tick();
    check("t1_busy", W'(busy), W'(0));
    check("t1_count0", W'(n_rsp0 - r0), W'(1));
    check("t1_count1", W'(n_rsp1 - r1), W'(0));

    // req1 result held back by rsp1_ready=0 for three cycles.
    f = '0;
    f[MUL_FLAG_HI] = 1'b1;
    rsp1_ready = 1'b0;
    r1 = n_rsp1;
    send(1, 64'd9, 64'd9, f, "t3");
    wait_res("t3");
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t3_hold_rdy%0d", i), W'(m_res_ready), W'(0));
      check($sformatf("t3_hold_v%0d", i), W'(rsp1_valid), W'(1));
      check($sformatf("t3_hold_res%0d", i), rsp_res, 64'd81);
      tick();
    end
    rsp1_ready = 1'b1;
    #1;
    check("t3_release", W'(m_res_ready), W'(1));
    tick();
    check("t3_delivered", W'(n_rsp1 - r1), W'(1));
    check("t3_busy", W'(busy), W'(0));

    // Both requesters contend for four grants: strict alternation from req0.
    base = grants.size();
    r0 = n_rsp0; r1 = n_rsp1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    k = 0;
    while (grants.size() < base + 4 && k < 100) begin
      req0_opa = 64'd100 + 64'(grants.size()); req0_opb = 64'd7;
      req1_opa = 64'd200 + 64'(grants.size()); req1_opb = 64'd11;
      tick();
      k++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("t2_four_grants", W'(k < 100), W'(1));
    for (int i = 0; i < 4; i++) begin
      if (grants.size() > base + i) check($sformatf("t2_order%0d", i), W'(grants[base + i]), W'(i % 2));
    end
    drain("t2");
    check("t2_rsp0", W'(n_rsp0 - r0), W'(2));
    check("t2_rsp1", W'(n_rsp1 - r1), W'(2));

    // Kill two in-flight req0 ops; a later req1 op still completes.
    mul_lat = 4;
    r0 = n_rsp0; r1 = n_rsp1;
    send(0, 64'd21, 64'd2, 4'b0000, "t4a");
    send(0, 64'd22, 64'd2, 4'b0000, "t4b");
    check("t4_full", W'(busy), W'(1));
    kill0 = 1'b1;
    tick();
    kill0 = 1'b0;
    send(1, 64'd23, 64'd3, 4'b0000, "t4c");
    drain("t4");
    check("t4_rsp0_dropped", W'(n_rsp0 - r0), W'(0));
    check("t4_rsp1", W'(n_rsp1 - r1), W'(1));

    // Kill coinciding with a head pop while full, plus a push attempt.
    mul_lat = 3;
    r0 = n_rsp0; r1 = n_rsp1;
    send(0, 64'd31, 64'd5, 4'b0000, "t5a");
    send(0, 64'd32, 64'd5, 4'b0000, "t5b");
    wait_res("t5");
    kill0 = 1'b1;
    req1_valid = 1'b1; req1_opa = 64'd33; req1_opb = 64'd5; req1_flags = 4'b0100;
    #1;
    check("t5_no_push_full", W'(req1_ready), W'(0));
    check("t5_head_v", W'(rsp0_valid), W'(1));
    check("t5_head_res", rsp_res, 64'd155);
    tick();
    kill0 = 1'b0;
    check("t5_head_delivered", W'(n_rsp0 - r0), W'(1));
    k = 0;
    while (!req1_ready && k < 50) begin tick(); k++; end
    check("t5_req1_later", W'(k < 50), W'(1));
    tick();
    req1_valid = 1'b0;
    drain("t5");
    check("t5_rsp0", W'(n_rsp0 - r0), W'(1));
    check("t5_rsp1", W'(n_rsp1 - r1), W'(1));

    // Reset with two ops in flight.
    mul_lat = 4;
    send(0, 64'd41, 64'd3, 4'b0000, "t6a");
    send(1, 64'd42, 64'd3, 4'b0000, "t6b");
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check("t6_busy", W'(busy), W'(0));
    check("t6_rsp_v", W'({rsp1_valid, rsp0_valid}), W'(0));
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("t6_prio", W'({req1_ready, req0_ready}), W'(2'b01));
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain("t6");

    // Mixed random traffic with stalls, back-pressure and occasional kills.
    for (int i = 0; i < 400; i++) begin
      req0_valid = $urandom_range(0, 1) == 1;
      req1_valid = $urandom_range(0, 1) == 1;
      req0_opa = {$urandom, $urandom}; req0_opb = W'($urandom_range(0, 1000));
      req1_opa = {$urandom, $urandom}; req1_opb = W'($urandom_range(0, 1000));
      req0_flags = 4'($urandom); req1_flags = 4'($urandom);
      kill0 = $urandom_range(0, 15) == 0;
      kill1 = $urandom_range(0, 15) == 0;
      rsp0_ready = $urandom_range(0, 3) != 0;
      rsp1_ready = $urandom_range(0, 3) != 0;
      m_allowin = $urandom_range(0, 4) != 0;
      mul_lat = $urandom_range(1, 4);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; kill0 = 1'b0; kill1 = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1; m_allowin = 1'b1;
    drain("rand");
    check("rand_idle", W'(busy), W'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_share_arb.md
Name: mul_share_arb

Overview:
- Shares one iterative 64x64 multiplier between two requesters: req0 is the integer EX pipe and req1 is the auxiliary unit (address-gen / CSR helper).
- Arbitrates round-robin and forwards the operands and op flags to the multiplier.
- Tracks in-flight ops in an in-order tag FIFO and routes each returned result to its owner.
- Supports per-requester kill, so flushed ops are drained and dropped.

Parameters:
- DEPTH, 2, maximum number of outstanding multiplier ops (tag FIFO entries); power of two, at least 1.
- W, 64, operand and result width.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset.
- reqN_valid  in  1  request valid (N=0,1; each reqN_* port exists per requester).
- reqN_ready  out  1  request accepted this cycle.
- reqN_opa, reqN_opb  in  W  operands.
- reqN_flags  in  4  {signed, mul64, hi, short}.
- killN  in  1  flush all of requester N's outstanding ops.
- rspN_valid  out  1  result valid for requester N.
- rspN_ready  in  1  requester N can take its result.
- rsp_res  out  W  result data, shared by both requesters.
- m_valid  out  1  issue to multiplier.
- m_allowin  in  1  multiplier can accept an op.
- m_opa, m_opb  out  W  muxed operands.
- m_flags  out  4  muxed flags.
- m_res_valid  in  1  multiplier result valid (results return in issue order).
- m_res_ready  out  1  result consumed.
- m_res  in  W  multiplier result.
- busy  out  1  outstanding count is nonzero.

Behaviour:
- Reset: rstn is synchronous and active-low; clock is clk. On reset the FIFO is empty, count=0 and rr_last=1 (req0 has priority first). All valid/ready outputs read 0 while rstn=0.
- can_issue = m_allowin && (count < DEPTH). count is the registered value; a pop in the same cycle does not free a slot for a push.
- Grant rules, all combinational:
  - reqN_ready = can_issue && !killN && (other requester not requesting, or rr_last != N).
  - The other requester counts as "requesting" only when it is valid and not killed.
  - At most one grant per cycle.
- Issue happens when reqN_valid && reqN_ready:
  - m_valid=1 and m_opa/m_opb/m_flags carry requester N's values.
  - Push {id=N, killed=0} into the FIFO.
  - rr_last<=N.
- With no grant, m_valid=0 and m_* carry req0's values (don't-care).
- Response routing uses the FIFO head {id, killed}:
  - rspN_valid = m_res_valid && count!=0 && !head.killed && head.id==N.
  - rsp_res = m_res, with no added latency (combinational path).
  - m_res_ready = (count==0) ? 1 : head.killed ? 1 : rsp[head.id]_ready.
  - Pop on m_res_valid && m_res_ready && count!=0.
- Kill:
  - killN sets killed=1 on every valid FIFO entry with id==N, in the same cycle's register update.
  - An entry popped in the kill cycle has already been delivered or dropped under the pre-kill head state; kill does not suppress rspN_valid in that cycle.
  - killN blocks a new grant to N in that cycle.
- Push and pop in the same cycle: count unchanged; pointers wrap modulo DEPTH.
- Protocol error: m_res_valid with count==0 is dropped (m_res_ready=1, no rsp valid). A simulation-only assertion flags it.
- No result is ever lost or duplicated. Each issued op produces exactly one pop.
- Latency through the block: 0 cycles on the issue path and 0 cycles on the response path.

Decomposition:
- Shared package holds:
  - mul_flags_t {signed, mul64, hi, short}.
  - req_id_t (1 bit).
  - tag_entry_t {id, killed}.
  - The MUL_FLAG_* bit-position constants.
- Sub-module mul_tag_fifo: DEPTH-entry circular FIFO of tag_entry_t.
  - Provides push, pop, count and head.
  - Provides a broadcast "mark killed where id==k" input.

Test Plan:
- Single req0 op (opa=3, opb=5, flags mul64=0), m_allowin=1, multiplier returns 15 after 2 cycles -> rsp0_valid with rsp_res=15, count returns to 0, rsp1_valid stays 0.
- Both requesters valid every cycle for 4 grants -> grants alternate req0, req1, req0, req1; ops 2 and 3 issue only after FIFO slots free (DEPTH=2); responses route by id in issue order.
- req1 result arrives while rsp1_ready=0 for 3 cycles -> m_res_ready=0, rsp1_valid held with stable rsp_res, pop only in the cycle rsp1_ready=1.
- Two req0 ops in flight, kill0 asserted for one cycle -> both results are consumed with m_res_ready=1 and rsp0_valid=0, count reaches 0, and req1 ops issued after the kill still return normally.
- Kill in the same cycle as a head pop, and push in the same cycle as a pop at count=DEPTH -> popped head is delivered, no push occurs (full is registered), pointers wrap correctly.
- Reset asserted mid-operation with 2 ops in flight -> next cycle busy=0, all rsp valids 0, rr_last=1; a subsequent simultaneous request is granted to req0.
